// File: rtl/sensor_timing_pkg.sv
// Shared definitions for the sensor timing controller: state encoding,
// counter width and the default timing parameters.
package sensor_timing_pkg;

   localparam int unsigned CNT_W = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LINE = 2'd1;
   localparam logic [1:0] ST_HBLK = 2'd2;
   localparam logic [1:0] ST_VBLK = 2'd3;

   localparam int unsigned PIX_DIV_MAX_DEF = 32'd4;
   localparam int unsigned LINE_PIX_DEF    = 32'd100;
   localparam int unsigned HBLANK_DEF      = 32'd20;
   localparam int unsigned LINES_DEF       = 32'd20;
   localparam int unsigned VBLANK_DEF      = 32'd4;

endpackage

// File: rtl/sensor_timing_ctrl_if.sv
// Control and timing bundle between the frame sequencer (slave side) and the
// host / pixel data generator (master side).
interface sensor_timing_ctrl_if;
   import sensor_timing_pkg::*;

   logic             start;
   logic             stop;
   logic             continuous;
   logic             pix_tick;
   logic             frame_valid;
   logic             line_valid;
   logic [CNT_W-1:0] pix_idx;
   logic [CNT_W-1:0] line_idx;
   logic             busy;
   logic             frame_done;
   logic [CNT_W-1:0] frame_cnt;

   modport slave (
      input  start, stop, continuous,
      output pix_tick, frame_valid, line_valid, pix_idx, line_idx,
             busy, frame_done, frame_cnt
   );

   modport master (
      output start, stop, continuous,
      input  pix_tick, frame_valid, line_valid, pix_idx, line_idx,
             busy, frame_done, frame_cnt
   );

endinterface

// File: rtl/sensor_timing_ctrl_pix_tick_div.sv
// Pixel-rate divider. enable and clear describe the cycle being entered, so
// pix_tick is a flop output that is high exactly when the count sits at
// DIV_MAX. tick_next exposes the same decision one cycle early.
module pix_tick_div
   import sensor_timing_pkg::*;
#(
   parameter int unsigned DIV_MAX = PIX_DIV_MAX_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic pix_tick,
   output logic tick_next
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_MAX);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             tick_r;

   // Next divider count: parked at zero when idle or restarted, else 0..DIV_MAX.
   always_comb begin
      cnt_s = 16'd0;
      if (!enable) begin
         cnt_s = 16'd0;
      end else if (clear) begin
         cnt_s = 16'd0;
      end else if (cnt_r == LAST) begin
         cnt_s = 16'd0;
      end else begin
         cnt_s = cnt_r + 16'd1;
      end
   end

   assign tick_next = enable && (cnt_s == LAST);

   // Divider count and registered tick strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= 16'd0;
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_s;
         tick_r <= tick_next;
      end
   end

   assign pix_tick = tick_r;

endmodule

// File: rtl/sensor_timing_ctrl.sv
// Frame/line timing sequencer for an image sensor data path. Walks active
// lines, horizontal blanking and vertical blanking on pixel ticks and reports
// frame completion. All status outputs are flops loaded from next-state values.
module sensor_timing_ctrl
   import sensor_timing_pkg::*;
#(
   parameter int unsigned PIX_DIV_MAX = PIX_DIV_MAX_DEF,
   parameter int unsigned LINE_PIX    = LINE_PIX_DEF,
   parameter int unsigned HBLANK      = HBLANK_DEF,
   parameter int unsigned LINES       = LINES_DEF,
   parameter int unsigned VBLANK      = VBLANK_DEF
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   sensor_timing_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(LINE_PIX - 32'd1);
   localparam logic [CNT_W-1:0] HBLK_LAST = CNT_W'(HBLANK - 32'd1);
   localparam logic [CNT_W-1:0] VPIX_LAST = CNT_W'(LINE_PIX + HBLANK - 32'd1);
   localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(LINES - 32'd1);
   localparam logic [CNT_W-1:0] VROW_LAST = CNT_W'(LINES + VBLANK - 32'd1);
   localparam logic             HB_SKIP   = (HBLANK == 32'd0);
   localparam logic             VB_SKIP   = (VBLANK == 32'd0);

   logic [1:0]       state_r, state_s;
   logic [CNT_W-1:0] pix_r, pix_s;
   logic [CNT_W-1:0] line_r, line_s;
   logic [CNT_W-1:0] frame_cnt_r, frame_cnt_s;
   logic             pend_r, pend_s;
   logic             line_valid_r, frame_valid_r, busy_r, frame_done_r;
   logic             tick_s, tick_next_s, done_next_s;
   logic             div_clear_s, div_enable_s;

   // True when a tick in this position is the last tick of the frame; empty
   // blanking regions move the frame end forward into HBLK or LINE.
   function automatic logic frame_last(input logic [1:0] st,
                                       input logic [CNT_W-1:0] pix,
                                       input logic [CNT_W-1:0] row);
      logic last_s;
      last_s = 1'b0;
      case (st)
         ST_LINE: last_s = HB_SKIP && VB_SKIP && (row == ROW_LAST) && (pix == PIX_LAST);
         ST_HBLK: last_s = VB_SKIP && (row == ROW_LAST) && (pix == HBLK_LAST);
         ST_VBLK: last_s = (row == VROW_LAST) && (pix == VPIX_LAST);
         default: last_s = 1'b0;
      endcase
      return last_s;
   endfunction

   pix_tick_div #(.DIV_MAX(PIX_DIV_MAX)) u_div (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .clear     (div_clear_s),
      .enable    (div_enable_s),
      .pix_tick  (tick_s),
      .tick_next (tick_next_s)
   );

   // Next-state logic: leave IDLE on a clean start, otherwise advance on ticks.
   always_comb begin
      state_s = state_r;
      pix_s   = pix_r;
      line_s  = line_r;
      if (state_r == ST_IDLE) begin
         if (bus.start && !bus.stop) begin
            state_s = ST_LINE;
            pix_s   = 16'd0;
            line_s  = 16'd0;
         end else begin
            state_s = ST_IDLE;
         end
      end else if (tick_s) begin
         if (frame_last(state_r, pix_r, line_r)) begin
            pix_s   = 16'd0;
            line_s  = 16'd0;
            state_s = (bus.continuous && !(pend_r || bus.stop)) ? ST_LINE : ST_IDLE;
         end else begin
            case (state_r)
               ST_LINE: begin
                  if (pix_r == PIX_LAST) begin
                     pix_s = 16'd0;
                     if (HB_SKIP) begin
                        line_s  = line_r + 16'd1;
                        state_s = (line_r == ROW_LAST) ? ST_VBLK : ST_LINE;
                     end else begin
                        state_s = ST_HBLK;
                     end
                  end else begin
                     pix_s = pix_r + 16'd1;
                  end
               end
               ST_HBLK: begin
                  if (pix_r == HBLK_LAST) begin
                     pix_s   = 16'd0;
                     line_s  = line_r + 16'd1;
                     state_s = (line_r == ROW_LAST) ? ST_VBLK : ST_LINE;
                  end else begin
                     pix_s = pix_r + 16'd1;
                  end
               end
               ST_VBLK: begin
                  if (pix_r == VPIX_LAST) begin
                     pix_s  = 16'd0;
                     line_s = line_r + 16'd1;
                  end else begin
                     pix_s = pix_r + 16'd1;
                  end
               end
               default: state_s = ST_IDLE;
            endcase
         end
      end else begin
         state_s = state_r;
      end
   end

   assign div_enable_s = (state_s != ST_IDLE);
   assign div_clear_s  = (state_r == ST_IDLE) && (state_s != ST_IDLE);
   assign done_next_s  = tick_next_s && frame_last(state_s, pix_s, line_s);
   assign frame_cnt_s  = frame_cnt_r + {15'd0, done_next_s};

   // Stop request latches while busy and is dropped whenever IDLE is entered.
   always_comb begin
      pend_s = pend_r;
      if (state_s == ST_IDLE) begin
         pend_s = 1'b0;
      end else if (bus.stop && (state_r != ST_IDLE)) begin
         pend_s = 1'b1;
      end else begin
         pend_s = pend_r;
      end
   end

   // Sequencer state and position counters.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r <= ST_IDLE;
         pix_r   <= 16'd0;
         line_r  <= 16'd0;
         pend_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         pix_r   <= pix_s;
         line_r  <= line_s;
         pend_r  <= pend_s;
      end
   end

   // Registered status outputs, aligned with the state they describe.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         line_valid_r  <= 1'b0;
         frame_valid_r <= 1'b0;
         busy_r        <= 1'b0;
         frame_done_r  <= 1'b0;
         frame_cnt_r   <= 16'd0;
      end else begin
         line_valid_r  <= (state_s == ST_LINE);
         frame_valid_r <= (state_s == ST_LINE) || (state_s == ST_HBLK);
         busy_r        <= (state_s != ST_IDLE);
         frame_done_r  <= done_next_s;
         frame_cnt_r   <= frame_cnt_s;
      end
   end

   assign bus.pix_tick    = tick_s;
   assign bus.frame_valid = frame_valid_r;
   assign bus.line_valid  = line_valid_r;
   assign bus.pix_idx     = pix_r;
   assign bus.line_idx    = line_r;
   assign bus.busy        = busy_r;
   assign bus.frame_done  = frame_done_r;
   assign bus.frame_cnt   = frame_cnt_r;

endmodule

// File: doc/sensor_timing_ctrl.md
SENSOR_TIMING_CTRL -- requirements
Module: sensor_timing_ctrl

Interface
REQ-001 Parameter PIX_DIV_MAX, default 4: pixel tick every PIX_DIV_MAX+1 sys_clk cycles.
REQ-002 Parameter LINE_PIX, default 100: active pixels per line.
REQ-003 Parameter HBLANK, default 20: blank pixel ticks after each line.
REQ-004 Parameter LINES, default 20: active lines per frame.
REQ-005 Parameter VBLANK, default 4: blank line periods after the last line, each LINE_PIX+HBLANK ticks.
REQ-006 sys_clk  in  1  single block clock; all logic on its rising edge.
REQ-007 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  one-cycle pulse; begin frame sequence.
REQ-009 stop  in  1  one-cycle pulse; request halt at next frame end.
REQ-010 continuous  in  1  level; 1 = back-to-back frames, 0 = single frame.
REQ-011 pix_tick  out  1  one-cycle pixel strobe for the data generator.
REQ-012 frame_valid  out  1  high from first line start to end of last line's HBLANK.
REQ-013 line_valid  out  1  high during active pixels of a line.
REQ-014 pix_idx  out  16  pixel index within current line/blank period.
REQ-015 line_idx  out  16  line index within frame, including VBLANK lines.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 frame_done  out  1  one-cycle pulse at frame end.
REQ-018 frame_cnt  out  16  completed frames, wraps 0xFFFF -> 0.

Function
REQ-019 States: IDLE, LINE, HBLK, VBLK; all non-IDLE transitions occur only on cycles with pix_tick=1.
REQ-020 Divider counts 0..PIX_DIV_MAX while busy; pix_tick=1 when divider==PIX_DIV_MAX; divider held at 0 in IDLE.
REQ-021 IDLE: start=1 and stop=0 -> LINE next cycle, pix_idx=0, line_idx=0, divider=0; start with stop same cycle is ignored.
REQ-022 LINE: line_valid=1; on tick with pix_idx==LINE_PIX-1 -> HBLK, pix_idx=0; otherwise pix_idx+1.
REQ-023 HBLK: on tick with pix_idx==HBLANK-1: line_idx==LINES-1 -> VBLK, else LINE; line_idx+1, pix_idx=0.
REQ-024 VBLK: frame_valid=0, line_valid=0; pix_idx wraps at LINE_PIX+HBLANK-1 and increments line_idx; on tick ending line LINES+VBLANK-1 the frame ends.
REQ-025 Frame end: frame_done=1 and frame_cnt+1 in that same cycle; next state LINE if continuous=1 and no stop pending, else IDLE.
REQ-026 stop while busy sets a pending flag, cleared on entry to IDLE; current frame always completes.
REQ-027 start while busy is ignored; stop in IDLE is ignored.
REQ-028 HBLANK=0 or VBLANK=0 skip the respective state without extra cycles.
REQ-029 frame_valid and line_valid are registered, glitch-free outputs; frame_valid=1 in LINE and HBLK only.
REQ-030 Changes to continuous take effect at the next frame end.

Reset
REQ-031 sys_rst_n=0 forces IDLE immediately, regardless of current state.
REQ-032 On reset: all outputs 0, frame_cnt=0, divider=0, stop pending cleared.
REQ-033 After release, no activity until a new start pulse.

Structure
REQ-034 Shared package sensor_timing_pkg holds the state enum and parameter default constants.
REQ-035 Single sub-module pix_tick_div (clear, enable, pix_tick).
REQ-036 Parameters require LINE_PIX>=1, LINES>=1, and every count < 2^16.

Verification (bench parameters: PIX_DIV_MAX=1, LINE_PIX=4, HBLANK=2, LINES=3, VBLANK=1)
REQ-037 Single frame: start at cycle 0, continuous=0 -> line_valid high in cycles 1-8, 13-20, 25-32; frame_valid high in 1-36; frame_done in cycle 48; busy=0 from 49; frame_cnt=1.
REQ-038 Continuous: continuous=1, start -> frame_done every 48 cycles; frame_valid re-asserts in cycle 49; frame_cnt=3 after 144 cycles.
REQ-039 Graceful stop: stop at cycle 10 of continuous run -> frame completes, frame_done at 48, IDLE at 49, no second frame.
REQ-040 Ignored commands: start at cycle 5 while busy and stop in IDLE -> no change in timing or state.
REQ-041 Reset mid-frame: sys_rst_n=0 at cycle 20 -> all outputs 0 the same cycle; restart after release matches REQ-037.
REQ-042 Wrap: frame_cnt preloaded to 0xFFFF by force -> after one frame reads 0x0000 with frame_done=1.
